// File: rtl/paddsb_seq_ctrl.sv
// Multicycle PADDSB sequencer: one shared LANE_W-bit saturating adder walks the
// lanes of a NIBBLES*LANE_W operand pair, LSB lane first, one lane per cycle.
module paddsb_seq_ctrl #(
   parameter int NIBBLES = 4,
   parameter int LANE_W  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        flush,
   input  logic [NIBBLES*LANE_W-1:0]   a,
   input  logic [NIBBLES*LANE_W-1:0]   b,
   output logic                        ready,
   output logic                        busy,
   output logic                        done,
   output logic [NIBBLES*LANE_W-1:0]   sum,
   output logic [NIBBLES-1:0]          sat_mask
);

   localparam int DATA_W = NIBBLES * LANE_W;
   localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    lane_idx_q, lane_idx_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [DATA_W-1:0]   sum_q, sum_d;
   logic [NIBBLES-1:0]  sat_mask_q, sat_mask_d;

   logic [LANE_W-1:0]   a_lane;
   logic [LANE_W-1:0]   b_lane;
   logic [LANE_W-1:0]   raw_lane;
   logic [LANE_W-1:0]   res_lane;
   logic                ovfl;

   // Shared lane adder: overflow only when both operands share a sign the wrap flips.
   always_comb begin
      a_lane   = a_q[lane_idx_q*LANE_W +: LANE_W];
      b_lane   = b_q[lane_idx_q*LANE_W +: LANE_W];
      raw_lane = a_lane + b_lane;
      ovfl     = (a_lane[LANE_W-1] == b_lane[LANE_W-1]) &&
                 (raw_lane[LANE_W-1] != a_lane[LANE_W-1]);
      res_lane = raw_lane;
      if (ovfl) begin
         res_lane = a_lane[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                     : {1'b0, {(LANE_W-1){1'b1}}};
      end
   end

   always_comb begin
      state_d    = state_q;
      lane_idx_d = lane_idx_q;
      a_d        = a_q;
      b_d        = b_q;
      sum_d      = sum_q;
      sat_mask_d = sat_mask_q;

      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               state_d    = ST_RUN;
               a_d        = a;
               b_d        = b;
               sum_d      = '0;
               sat_mask_d = '0;
               lane_idx_d = '0;
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else begin
               sum_d[lane_idx_q*LANE_W +: LANE_W] = res_lane;
               sat_mask_d[lane_idx_q]             = ovfl;
               if (lane_idx_q == LAST_IDX) begin
                  lane_idx_d = '0;
                  state_d    = ST_DONE;
               end else begin
                  lane_idx_d = lane_idx_q + 1'b1;
               end
            end
         end
         ST_DONE: begin
            if (flush) begin
               state_d = ST_IDLE;
            end else if (start) begin
               state_d    = ST_RUN;
               a_d        = a;
               b_d        = b;
               sum_d      = '0;
               sat_mask_d = '0;
               lane_idx_d = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         lane_idx_q <= '0;
         a_q        <= '0;
         b_q        <= '0;
         sum_q      <= '0;
         sat_mask_q <= '0;
      end else begin
         state_q    <= state_d;
         lane_idx_q <= lane_idx_d;
         a_q        <= a_d;
         b_q        <= b_d;
         sum_q      <= sum_d;
         sat_mask_q <= sat_mask_d;
      end
   end

   // A flush landing on the DONE cycle suppresses the pulse so the result is never claimed.
   assign ready    = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE) && !flush;
   assign sum      = sum_q;
   assign sat_mask = sat_mask_q;

endmodule

// File: tb/tb_paddsb_seq_ctrl.sv
// Scoreboard bench for paddsb_seq_ctrl: expected {sat_mask,sum} pushed at start,
// popped and compared when done pulses.
module tb_paddsb_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        ready;
   logic        busy;
   logic        done;
   logic [15:0] sum;
   logic [3:0]  sat_mask;

   int n_cmp = 0;
   int n_err = 0;
   logic [19:0] exp_q[$];

   always #5 clk = ~clk;

   paddsb_seq_ctrl #(.NIBBLES(4), .LANE_W(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .flush    (flush),
      .a        (a),
      .b        (b),
      .ready    (ready),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .sat_mask (sat_mask)
   );

   // Reference: signed integer add per lane, clamped to [-8,7].
   function automatic logic [19:0] model(input logic [15:0] oa, input logic [15:0] ob);
      logic [15:0] s;
      logic [3:0]  m;
      logic signed [3:0] la;
      logic signed [3:0] lb;
      int t;
      s = '0;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         la = oa[i*4 +: 4];
         lb = ob[i*4 +: 4];
         t  = int'(la) + int'(lb);
         if (t > 7) begin
            t = 7;
            m[i] = 1'b1;
         end else if (t < -8) begin
            t = -8;
            m[i] = 1'b1;
         end
         s[i*4 +: 4] = 4'(t);
      end
      return {m, s};
   endfunction

   task automatic wait_done(input int max_edges, output int edges, output bit seen);
      edges = 0;
      seen  = 1'b0;
      while (edges < max_edges && !seen) begin
         @(negedge clk);
         edges++;
         seen = done;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready got=%b want=1", ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done got=%b want=0", done); end
      n_cmp++; if (sum !== 16'h0) begin n_err++; $display("[TB] FAIL reset_sum got=%h want=0000", sum); end
      n_cmp++; if (sat_mask !== 4'h0) begin n_err++; $display("[TB] FAIL reset_mask got=%b want=0000", sat_mask); end
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input string tag);
      int edges;
      bit seen;
      logic [19:0] exp;
      logic [15:0] held;
      @(negedge clk);
      a = oa;
      b = ob;
      start = 1'b1;
      exp_q.push_back(model(oa, ob));
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL %s_busy got=%b want=1", tag, busy); end
      wait_done(12, edges, seen);
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("[TB] FAIL %s_timeout got=no_done want=done", tag);
      end else begin
         if (edges !== 4) begin n_err++; $display("[TB] FAIL %s_latency got=%0d want=4", tag, edges); end
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("[TB] FAIL %s_scoreboard got=empty want=entry", tag);
         end else begin
            exp = exp_q.pop_front();
            if (sum !== exp[15:0]) begin n_err++; $display("[TB] FAIL %s_sum got=%h want=%h", tag, sum, exp[15:0]); end
            n_cmp++;
            if (sat_mask !== exp[19:16]) begin n_err++; $display("[TB] FAIL %s_mask got=%b want=%b", tag, sat_mask, exp[19:16]); end
         end
         held = sum;
         @(negedge clk);
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL %s_pulse got=%b want=0", tag, done); end
         n_cmp++; if (sum !== held) begin n_err++; $display("[TB] FAIL %s_hold got=%h want=%h", tag, sum, held); end
      end
   endtask

   task automatic test_basic();
      run_op(16'h1234, 16'h1111, "plain");
      run_op(16'h7777, 16'h1111, "possat");
      run_op(16'h8888, 16'h8888, "negsat");
      run_op(16'h70F8, 16'h1F08, "mixed");
   endtask

   task automatic test_back_to_back();
      int c1;
      int c2;
      logic [19:0] exp;
      @(negedge clk);
      a = 16'h4321;
      b = 16'h2222;
      start = 1'b1;
      exp_q.push_back(model(16'h4321, 16'h2222));
      c1 = 0;
      while (c1 < 12) begin
         @(negedge clk);
         c1++;
         if (done) break;
         a = 16'($urandom);
         b = 16'($urandom);
      end
      n_cmp++; if (c1 !== 5) begin n_err++; $display("[TB] FAIL hold_first_done got=%0d want=5", c1); end
      exp = exp_q.pop_front();
      n_cmp++; if (sum !== exp[15:0]) begin n_err++; $display("[TB] FAIL hold_sum got=%h want=%h", sum, exp[15:0]); end
      n_cmp++; if (sat_mask !== exp[19:16]) begin n_err++; $display("[TB] FAIL hold_mask got=%b want=%b", sat_mask, exp[19:16]); end
      a = 16'h8F17;
      b = 16'hF0E2;
      exp_q.push_back(model(16'h8F17, 16'hF0E2));
      c2 = 0;
      while (c2 < 12) begin
         @(negedge clk);
         c2++;
         if (c2 == 1) start = 1'b0;
         if (done) break;
      end
      n_cmp++; if (c2 !== 5) begin n_err++; $display("[TB] FAIL b2b_gap got=%0d want=5", c2); end
      exp = exp_q.pop_front();
      n_cmp++; if (sum !== exp[15:0]) begin n_err++; $display("[TB] FAIL b2b_sum got=%h want=%h", sum, exp[15:0]); end
      n_cmp++; if (sat_mask !== exp[19:16]) begin n_err++; $display("[TB] FAIL b2b_mask got=%b want=%b", sat_mask, exp[19:16]); end
      @(negedge clk);
   endtask

   task automatic test_flush();
      int pulses;
      @(negedge clk);
      a = 16'h1357;
      b = 16'h2468;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("[TB] FAIL flush_ready got=%b want=1", ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL flush_busy got=%b want=0", busy); end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("[TB] FAIL flush_no_done got=%0d want=0", pulses); end
      flush = 1'b1;
      start = 1'b1;
      a = 16'h1111;
      b = 16'h1111;
      @(negedge clk);
      flush = 1'b0;
      start = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL flushstart_busy got=%b want=0", busy); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("[TB] FAIL flushstart_ready got=%b want=1", ready); end
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) pulses++;
         @(negedge clk);
      end
      n_cmp++; if (pulses !== 0) begin n_err++; $display("[TB] FAIL flushstart_no_done got=%0d want=0", pulses); end
   endtask

   task automatic test_reset_mid_run();
      @(negedge clk);
      a = 16'h3535;
      b = 16'h2121;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL midrst_done got=%b want=0", done); end
      n_cmp++; if (sum !== 16'h0) begin n_err++; $display("[TB] FAIL midrst_sum got=%h want=0000", sum); end
      n_cmp++; if (sat_mask !== 4'h0) begin n_err++; $display("[TB] FAIL midrst_mask got=%b want=0000", sat_mask); end
      n_cmp++; if (ready !== 1'b1) begin n_err++; $display("[TB] FAIL midrst_ready got=%b want=1", ready); end
      @(negedge clk);
      rst_n = 1'b1;
      run_op(16'h0F7A, 16'h01C9, "after_rst");
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         run_op(16'($urandom), 16'($urandom), "rand");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_flush();
      test_reset_mid_run();
      test_random();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("[TB] FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
